// File: rtl/smg_pkg.sv
// Shared definitions for the 7-segment scan controller: font, frame layout, FSM states.
package smg_pkg;

  // Frame layout: {seg[7:0], sel[7:0]}, shifted MSB first
  localparam int unsigned SEG_MSB = 15;
  localparam int unsigned SEL_MSB = 7;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned SEL_W   = 8;

  // Active-high segment font, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] FONT_0 = 7'h3F;
  localparam logic [6:0] FONT_1 = 7'h06;
  localparam logic [6:0] FONT_2 = 7'h5B;
  localparam logic [6:0] FONT_3 = 7'h4F;
  localparam logic [6:0] FONT_4 = 7'h66;
  localparam logic [6:0] FONT_5 = 7'h6D;
  localparam logic [6:0] FONT_6 = 7'h7D;
  localparam logic [6:0] FONT_7 = 7'h07;
  localparam logic [6:0] FONT_8 = 7'h7F;
  localparam logic [6:0] FONT_9 = 7'h6F;
  localparam logic [6:0] FONT_A = 7'h77;
  localparam logic [6:0] FONT_B = 7'h7C;
  localparam logic [6:0] FONT_C = 7'h39;
  localparam logic [6:0] FONT_D = 7'h5E;
  localparam logic [6:0] FONT_E = 7'h79;
  localparam logic [6:0] FONT_F = 7'h71;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUILD = 3'd1,
    ST_SEND  = 3'd2,
    ST_DWELL = 3'd3,
    ST_BLANK = 3'd4
  } smg_state_e;

endpackage

// File: rtl/smg_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module smg_hex_decode
  import smg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  // Font lookup
  always_comb begin
    seg_c = FONT_0;
    case (hex)
      4'h0: seg_c = FONT_0;
      4'h1: seg_c = FONT_1;
      4'h2: seg_c = FONT_2;
      4'h3: seg_c = FONT_3;
      4'h4: seg_c = FONT_4;
      4'h5: seg_c = FONT_5;
      4'h6: seg_c = FONT_6;
      4'h7: seg_c = FONT_7;
      4'h8: seg_c = FONT_8;
      4'h9: seg_c = FONT_9;
      4'hA: seg_c = FONT_A;
      4'hB: seg_c = FONT_B;
      4'hC: seg_c = FONT_C;
      4'hD: seg_c = FONT_D;
      4'hE: seg_c = FONT_E;
      4'hF: seg_c = FONT_F;
    endcase
  end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Scan scheduler for a multiplexed 7-segment display behind a 74HC595 serializer.
// Optional build macro SMG_ZERO_BLANK_EN: suppress leading zeros (digit 0 always shown).
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned DWELL_CNT  = 50000,
  parameter bit          SEG_ACT_LO = 1'b1,
  parameter bit          SEL_ACT_LO = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4*DIGITS-1:0]          digit_data,
  input  logic [DIGITS-1:0]            dp_mask,
  input  logic                         load,
  input  logic                         disp_en,
  output logic                         frame_vld,
  input  logic                         frame_rdy,
  output logic [15:0]                  frame_data,
  output logic [$clog2(DIGITS)-1:0]    scan_idx,
  output logic                         busy
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned CNT_W = (DWELL_CNT > 1) ? $clog2(DWELL_CNT) : 1;
  localparam logic [15:0] BLANK_FRAME = {(SEG_ACT_LO ? 8'hFF : 8'h00),
                                         (SEL_ACT_LO ? 8'hFF : 8'h00)};

  smg_state_e              state_q, state_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0]             frame_data_q, frame_data_d;
  logic                    frame_vld_q, frame_vld_d;
  logic                    busy_q, busy_d;
  logic [4*DIGITS-1:0]     pend_data_q, pend_data_d;
  logic [DIGITS-1:0]       pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*DIGITS-1:0]     shad_data_q, shad_data_d;
  logic [DIGITS-1:0]       shad_dp_q, shad_dp_d;

  logic                    xfer;
  logic [4*DIGITS-1:0]     eff_data;
  logic [DIGITS-1:0]       eff_dp;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [6:0]              font_seg;
  logic [7:0]              seg_act;
  logic [7:0]              sel_act;
  logic [15:0]             digit_frame;

  smg_hex_decode u_dec (
    .hex   (cur_nib),
    .seg_c (font_seg)
  );

  // Select the digit being built; the sweep-start transfer is visible in the same frame
  always_comb begin
    xfer     = (state_q == ST_BUILD) && (scan_idx_q == '0) && pend_flag_q;
    eff_data = xfer ? pend_data_q : shad_data_q;
    eff_dp   = xfer ? pend_dp_q   : shad_dp_q;
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        cur_nib = eff_data[4*i +: 4];
        cur_dp  = eff_dp[i];
      end
    end
  end

`ifdef SMG_ZERO_BLANK_EN
  logic lead_zero;

  // Leading-zero suppression scanning down from the most significant digit
  always_comb begin
    lead_zero = 1'b1;
    cur_blank = 1'b0;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      lead_zero = lead_zero && (eff_data[4*i +: 4] == 4'h0);
      if (scan_idx_q == IDX_W'(i)) begin
        cur_blank = lead_zero && !eff_dp[i];
      end
    end
  end
`else
  // Every digit always shows its value
  always_comb begin
    cur_blank = 1'b0;
  end
`endif

  // Assemble the digit frame with output polarity applied
  always_comb begin
    seg_act     = cur_blank ? 8'h00 : {cur_dp, font_seg};
    sel_act     = 8'd1 << scan_idx_q;
    digit_frame = '0;
    digit_frame[SEG_MSB -: SEG_W] = SEG_ACT_LO ? ~seg_act : seg_act;
    digit_frame[SEL_MSB -: SEL_W] = SEL_ACT_LO ? ~sel_act : sel_act;
  end

  // Next-state, load capture and registered-output computation
  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    cnt_d        = cnt_q;
    frame_data_d = frame_data_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q && !xfer;
    shad_data_d  = shad_data_q;
    shad_dp_d    = shad_dp_q;

    if (xfer) begin
      shad_data_d = pend_data_q;
      shad_dp_d   = pend_dp_q;
    end
    if (load) begin
      pend_data_d = digit_data;
      pend_dp_d   = dp_mask;
      pend_flag_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (disp_en) begin
          state_d    = ST_BUILD;
          scan_idx_d = '0;
        end
      end
      ST_BUILD: begin
        if (disp_en) begin
          state_d      = ST_SEND;
          frame_data_d = digit_frame;
        end else begin
          state_d      = ST_BLANK;
          frame_data_d = BLANK_FRAME;
        end
      end
      ST_SEND: begin
        if (frame_rdy) begin
          if (disp_en) begin
            state_d = ST_DWELL;
            cnt_d   = '0;
          end else begin
            state_d      = ST_BLANK;
            frame_data_d = BLANK_FRAME;
          end
        end
      end
      ST_DWELL: begin
        if (!disp_en) begin
          state_d      = ST_BLANK;
          frame_data_d = BLANK_FRAME;
        end else if (cnt_q == CNT_W'(DWELL_CNT - 1)) begin
          state_d    = ST_BUILD;
          scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BLANK: begin
        if (frame_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    frame_vld_d = (state_d == ST_SEND) || (state_d == ST_BLANK);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      scan_idx_q   <= '0;
      cnt_q        <= '0;
      frame_data_q <= '0;
      frame_vld_q  <= 1'b0;
      busy_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      shad_data_q  <= '0;
      shad_dp_q    <= '0;
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      cnt_q        <= cnt_d;
      frame_data_q <= frame_data_d;
      frame_vld_q  <= frame_vld_d;
      busy_q       <= busy_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      shad_data_q  <= shad_data_d;
      shad_dp_q    <= shad_dp_d;
    end
  end

  assign frame_vld  = frame_vld_q;
  assign frame_data = frame_data_q;
  assign scan_idx   = scan_idx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Randomized self-checking bench for smg_scan_ctrl (4 digits, short dwell).
module tb_smg_scan_ctrl;

  localparam int DIG = 4;
  localparam int DW  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digit_data;
  logic [3:0]  dp_mask;
  logic        load;
  logic        disp_en;
  logic        frame_vld;
  logic        frame_rdy;
  logic [15:0] frame_data;
  logic [1:0]  scan_idx;
  logic        busy;

  smg_scan_ctrl #(
    .DIGITS     (DIG),
    .DWELL_CNT  (DW),
    .SEG_ACT_LO (1'b1),
    .SEL_ACT_LO (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_data (digit_data),
    .dp_mask    (dp_mask),
    .load       (load),
    .disp_en    (disp_en),
    .frame_vld  (frame_vld),
    .frame_rdy  (frame_rdy),
    .frame_data (frame_data),
    .scan_idx   (scan_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [6:0]  font [16];
  logic [15:0] ld_last_d, ld_prev_d, sh_d, held;
  logic [3:0]  ld_last_p, ld_prev_p, sh_p;
  logic        vld_p, acc_p, en_p, restart, last_digit, cur_is_blank, blank_done_p, rise_pend;
  int          last_idx, acc_step, rise_step, stepn;
  logic [15:0] lit_q [$];

  function automatic logic [15:0] exp_frame(input logic [15:0] d, input logic [3:0] dp, input int idx);
    logic [7:0] seg;
    logic [7:0] sel;
    logic [3:0] nib;
    nib = d[4*idx +: 4];
    seg = {dp[idx], font[nib]};
`ifdef SMG_ZERO_BLANK_EN
    begin
      bit blank;
      blank = (idx > 0) && !dp[idx];
      for (int j = idx; j < DIG; j++) if (d[4*j +: 4] != 4'h0) blank = 1'b0;
      if (blank) seg = 8'h00;
    end
`endif
    sel = 8'hFF;
    sel[idx] = 1'b0;
    return {~seg, sel};
  endfunction

  // One cycle: observe at the falling edge, check against the model, then drive inputs
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p,
                      input logic en, input logic rdy);
    logic        vld;
    logic [15:0] dat;
    logic        nw;
    logic        acc;
    int          idx;
    vld = frame_vld;
    dat = frame_data;
    nw  = vld && (!vld_p || acc_p);
    if (blank_done_p) begin
      chk("idle_vld", 32'(vld), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    if (nw) begin
      if (!en_p) begin
        chk("blank", 32'(dat), 32'hFFFF);
        restart      = 1'b1;
        last_digit   = 1'b0;
        rise_pend    = 1'b0;
        cur_is_blank = 1'b1;
      end else begin
        idx = restart ? 0 : (last_idx + 1) % DIG;
        if (idx == 0) begin
          sh_d = ld_prev_d;
          sh_p = ld_prev_p;
        end
        chk("frame", 32'(dat), 32'(exp_frame(sh_d, sh_p, idx)));
        chk("idx", 32'(scan_idx), 32'(idx));
        if (lit_q.size() > 0) chk("lit", 32'(dat), 32'(lit_q.pop_front()));
        if (!restart && last_digit) chk("gap", 32'(stepn - acc_step), 32'(DW + 2));
        if (rise_pend) chk("lat", 32'(stepn - rise_step), 32'd2);
        rise_pend    = 1'b0;
        restart      = 1'b0;
        last_idx     = idx;
        last_digit   = 1'b1;
        cur_is_blank = 1'b0;
      end
      held = dat;
    end else if (vld) begin
      chk("hold", 32'(dat), 32'(held));
    end

    if (!en_p && en && !busy && !vld) begin
      rise_pend = 1'b1;
      rise_step = stepn;
    end
    disp_en    = en;
    frame_rdy  = rdy;
    load       = ld;
    digit_data = d;
    dp_mask    = p;
    acc        = vld && rdy;
    ld_prev_d  = ld_last_d;
    ld_prev_p  = ld_last_p;
    if (ld) begin
      ld_last_d = d;
      ld_last_p = p;
    end
    if (acc) acc_step = stepn;
    blank_done_p = acc && cur_is_blank && !en;
    acc_p = acc;
    vld_p = vld;
    en_p  = en;
    stepn++;
    @(negedge clk);
  endtask

  initial begin
    logic        en, rdy, ld, found;
    logic [15:0] d;
    logic [3:0]  p;
    int          stall, off;

    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst = 1'b1; load = 1'b0; disp_en = 1'b0; frame_rdy = 1'b0;
    digit_data = '0; dp_mask = '0;
    ld_last_d = '0; ld_prev_d = '0; sh_d = '0; held = '0;
    ld_last_p = '0; ld_prev_p = '0; sh_p = '0;
    vld_p = 0; acc_p = 0; en_p = 0; restart = 1; last_digit = 0;
    cur_is_blank = 0; blank_done_p = 0; rise_pend = 0;
    last_idx = 0; acc_step = 0; rise_step = 0; stepn = 0;
    stall = 0; off = 0;

    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(frame_vld), 32'd0);
    chk("rst_data", 32'(frame_data), 32'd0);
    chk("rst_idx", 32'(scan_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known pattern, always-ready serializer
    lit_q = '{16'h99FE, 16'hB0FD, 16'hA4FB, 16'hF9F7, 16'h99FE};
    step(1'b1, 16'h1234, 4'h0, 1'b0, 1'b1);
    for (int s = 0; s < 70; s++) step(1'b0, 16'($urandom), 4'($urandom), 1'b1, 1'b1);
    chk("lit_done", 32'(lit_q.size()), 32'd0);

    // Randomized traffic: stalls, loads at any phase, display on/off
    for (int s = 0; s < 2500; s++) begin
      if (stall > 0) stall--;
      else if ($urandom_range(0, 39) == 0) stall = 7;
      rdy = (stall == 0) && ($urandom_range(0, 4) != 0);
      if (off > 0) begin
        off--;
        en = (off == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        off = $urandom_range(1, 25);
        en  = 1'b0;
      end else begin
        en = 1'b1;
      end
      ld = ($urandom_range(0, 29) == 0);
      d  = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d[15:8] = 8'h00;
      p  = 4'($urandom);
      if ($urandom_range(0, 1) == 0) p = 4'h0;
      step(ld, d, p, en, rdy);
    end

    // Asynchronous reset while a frame is being offered at a nonzero index
    found = 1'b0;
    for (int s = 0; s < 400 && !found; s++) begin
      if (frame_vld && scan_idx == 2'd2) found = 1'b1;
      else step(1'b0, 16'h1234, 4'h0, 1'b1, 1'b1);
    end
    chk("find_idx2", 32'(found), 32'd1);
    frame_rdy = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", 32'(frame_vld), 32'd0);
    chk("arst_data", 32'(frame_data), 32'd0);
    chk("arst_idx", 32'(scan_idx), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
